// File: rtl/mem_readback_checker.sv
// Sweeps RAM port B across every address and compares each word with {~addr, addr},
// counting mismatches and capturing the first failing address and data.
`timescale 1ns / 1ps
module mem_readback_checker #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk40m,
  input  logic              RSTN,
  input  logic              start,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int unsigned EW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic [RD_LAT*EW-1:0] pipe_q;
  logic [(RD_LAT+1)*EW-1:0] pipe_ext;
  logic [EW-1:0]       out_entry;
  logic [DATA_W-1:0]   expected;
  logic                clr, hit;
  logic                busy_q, done_q, pass_q, mismatch_q;
  logic                busy_d, done_d, pass_d, mismatch_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fea_q, fea_d;
  logic [DATA_W-1:0]   fed_q, fed_d;

  // Stage entry is {valid, addr}; the oldest entry sits in the top slot of pipe_ext.
  assign pipe_ext  = {pipe_q, (state_q == StRead), addrb_q};
  assign out_entry = pipe_ext[(RD_LAT+1)*EW-1 -: EW];
  assign expected  = {~out_entry[ADDR_W-1:0], out_entry[ADDR_W-1:0]};

  always_comb begin
    state_d = state_q;
    addrb_d = addrb_q;
    dcnt_d  = dcnt_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRead;
          addrb_d = '0;
          clr     = 1'b1;
        end
      end
      StRead: begin
        if (addrb_q == '1) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          addrb_d = addrb_q + 1'b1;
        end
      end
      StDrain: begin
        if (dcnt_q == 2'(RD_LAT - 1)) state_d = StDone;
        else dcnt_d = dcnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hit        = out_entry[ADDR_W] && (doutb != expected);
    err_d      = err_q;
    fea_d      = fea_q;
    fed_d      = fed_q;
    mismatch_d = 1'b0;
    if (clr) begin
      err_d = '0;
      fea_d = '0;
      fed_d = '0;
    end else if (hit) begin
      mismatch_d = 1'b1;
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fea_d = out_entry[ADDR_W-1:0];
        fed_d = doutb;
      end
    end
    busy_d = (state_d == StRead) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk40m or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= StIdle;
      addrb_q    <= '0;
      dcnt_q     <= '0;
      pipe_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      fea_q      <= '0;
      fed_q      <= '0;
    end else begin
      state_q    <= state_d;
      addrb_q    <= addrb_d;
      dcnt_q     <= dcnt_d;
      pipe_q     <= clr ? '0 : pipe_ext[RD_LAT*EW-1:0];
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      fea_q      <= fea_d;
      fed_q      <= fed_d;
    end
  end

  assign addrb          = addrb_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch       = mismatch_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;

endmodule

// File: tb/tb_mem_readback_checker.sv
// Scoreboard bench: sweeps push expected results, a negedge monitor compares them on done.
`timescale 1ns / 1ps
module tb_mem_readback_checker;

  logic clk40m = 1'b0;
  logic RSTN;
  always #5 clk40m = ~clk40m;

  // Main DUT, RD_LAT=1, backed by an editable RAM model
  logic        start;
  logic [7:0]  addrb, fea;
  logic [15:0] doutb, fed, err_count;
  logic        busy, done, pass, mismatch;
  logic [15:0] mem [256];

  mem_readback_checker #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
    .clk40m(clk40m), .RSTN(RSTN), .start(start), .addrb(addrb), .doutb(doutb),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_count(err_count),
    .first_err_addr(fea), .first_err_data(fed)
  );
  always @(posedge clk40m) doutb <= mem[addrb];

  // RD_LAT=3 DUT, every word wrong
  logic        start3;
  logic [7:0]  addrb3, fea3;
  logic [15:0] doutb3, fed3, err3, r0, r1;
  logic        busy3, done3, pass3, mm3;

  mem_readback_checker #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk40m(clk40m), .RSTN(RSTN), .start(start3), .addrb(addrb3), .doutb(doutb3),
    .busy(busy3), .done(done3), .pass(pass3), .mismatch(mm3), .err_count(err3),
    .first_err_addr(fea3), .first_err_data(fed3)
  );
  always @(posedge clk40m) begin
    r0     <= {~addrb3, addrb3} ^ 16'h0101;
    r1     <= r0;
    doutb3 <= r1;
  end

  // Narrow-counter DUT for saturation, every word wrong
  logic        starts;
  logic [7:0]  addrbs, feas;
  logic [15:0] doutbs, feds;
  logic [3:0]  errs;
  logic        busys, doness, passs, mms;

  mem_readback_checker #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .ERR_W(4)) dut_sat (
    .clk40m(clk40m), .RSTN(RSTN), .start(starts), .addrb(addrbs), .doutb(doutbs),
    .busy(busys), .done(doness), .pass(passs), .mismatch(mms), .err_count(errs),
    .first_err_addr(feas), .first_err_data(feds)
  );
  always @(posedge clk40m) doutbs <= {~addrbs, addrbs} ^ 16'h8000;

  typedef struct {
    int          err;
    logic [7:0]  fa;
    logic [15:0] fd;
    logic        pass;
    int          mm;
    int          busy;
    int          done_edge;
  } exp_t;

  exp_t sb [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial forever begin
    @(posedge clk40m);
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Monitor: accumulates mismatch/busy cycles, compares the head expectation when done rises
  initial begin
    int   mm_cnt = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk40m);
      if (!RSTN) begin
        mm_cnt = 0;
        busy_cnt = 0;
        done_prev = 1'b0;
      end else begin
        if (mismatch) mm_cnt++;
        if (busy) busy_cnt++;
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
          end else begin
            e = sb.pop_front();
            check("err_count", 32'(err_count), 32'(e.err));
            check("first_err_addr", 32'(fea), 32'(e.fa));
            check("first_err_data", 32'(fed), 32'(e.fd));
            check("pass", 32'(pass), 32'(e.pass));
            check("mismatch_cycles", 32'(mm_cnt), 32'(e.mm));
            check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
            check("done_edge", 32'(cyc), 32'(e.done_edge));
          end
          mm_cnt = 0;
          busy_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  task automatic issue(input int err, input logic [7:0] fa, input logic [15:0] fd,
                       input logic ps, input int mm);
    @(negedge clk40m);
    sb.push_back('{err: err, fa: fa, fd: fd, pass: ps, mm: mm, busy: 257,
                   done_edge: cyc + 1 + 257});
    start = 1'b1;
    @(negedge clk40m);
    start = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk40m);
      i++;
    end
    if (sb.size() != 0) begin
      check("sweep_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addrb"}, 32'(addrb), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_mismatch"}, 32'(mismatch), 32'(0));
    check({tag, "_err_count"}, 32'(err_count), 32'(0));
    check({tag, "_fea"}, 32'(fea), 32'(0));
    check({tag, "_fed"}, 32'(fed), 32'(0));
  endtask

  initial begin
    int e0;
    int i;
    RSTN = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    starts = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = {~8'(a), 8'(a)};
    repeat (3) @(negedge clk40m);
    check_reset_vals("rst");
    RSTN = 1'b1;
    repeat (2) @(negedge clk40m);

    // Clean sweep on main DUT; all-wrong sweeps on the RD_LAT=3 and narrow-counter DUTs
    e0 = cyc + 1;
    start3 = 1'b1;
    starts = 1'b1;
    sb.push_back('{err: 0, fa: 8'h00, fd: 16'h0000, pass: 1'b1, mm: 0, busy: 257,
                   done_edge: e0 + 257});
    start = 1'b1;
    @(negedge clk40m);
    start = 1'b0;
    start3 = 1'b0;
    starts = 1'b0;
    wait_sb(400);
    check("addrb_hold", 32'(addrb), 32'h0000_00ff);
    i = 0;
    while (!done3 && i < 20) begin
      @(negedge clk40m);
      i++;
    end
    check("lat3_done_edge", 32'(cyc), 32'(e0 + 259));
    check("lat3_err_count", 32'(err3), 32'd256);
    check("lat3_addrb", 32'(addrb3), 32'h0000_00ff);
    check("lat3_pass", 32'(pass3), 32'(0));
    check("sat_err_count", 32'(errs), 32'h0000_000f);
    check("sat_done", 32'(doness), 32'(1));

    // Two corrupted words plus an ignored start mid-sweep
    mem[8'h37] = 16'h0000;
    mem[8'hA0] = 16'hFFFF;
    issue(2, 8'h37, 16'h0000, 1'b0, 2);
    repeat (99) @(negedge clk40m);
    start = 1'b1;
    @(negedge clk40m);
    start = 1'b0;
    wait_sb(400);

    // Restart with start held in DONE: results clear on the accepting edge
    mem[8'h37] = 16'hC837;
    mem[8'hA0] = 16'h5FA0;
    sb.push_back('{err: 0, fa: 8'h00, fd: 16'h0000, pass: 1'b1, mm: 0, busy: 257,
                   done_edge: cyc + 1 + 257});
    start = 1'b1;
    @(negedge clk40m);
    check("restart_done", 32'(done), 32'(0));
    check("restart_err", 32'(err_count), 32'(0));
    check("restart_fea", 32'(fea), 32'(0));
    check("restart_busy", 32'(busy), 32'(1));
    repeat (2) @(negedge clk40m);
    start = 1'b0;
    wait_sb(400);

    // Reset mid-READ at addrb=0x80, then a clean sweep
    @(negedge clk40m);
    start = 1'b1;
    @(negedge clk40m);
    start = 1'b0;
    i = 0;
    while (addrb != 8'h80 && i < 300) begin
      @(negedge clk40m);
      i++;
    end
    check("reached_80", 32'(addrb), 32'h0000_0080);
    #2 RSTN = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk40m);
    RSTN = 1'b1;
    @(negedge clk40m);
    issue(0, 8'h00, 16'h0000, 1'b1, 0);
    wait_sb(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_readback_checker.md
# mem_readback_checker

Readback verifier that sits directly downstream of the 256×16 dual-port block-RAM write stage. After the writer has filled the RAM, the checker sweeps read port B across every address and compares each word against the expected pattern {~addr, addr}. It counts mismatches, captures the first failing address and data, and reports pass/fail for the ILA and the LED logic.

## Interface
Parameters:
- ADDR_W, 8, address width; the sweep covers 2^ADDR_W words.
- DATA_W, 16, data width; must equal 2*ADDR_W.
- RD_LAT, 1, read latency of port B in cycles, from addrb to valid doutb; legal values 1–3.

Ports:
- clk40m  in  1  40 MHz system clock; all logic on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- start  in  1  request a sweep; sampled only in IDLE or DONE.
- addrb  out  ADDR_W  read address to RAM port B.
- doutb  in  DATA_W  read data from RAM port B.
- busy  out  1  high while in READ or DRAIN.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  done && (err_count == 0).
- mismatch  out  1  one-cycle pulse per failing compare.
- err_count  out  16  number of mismatches; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch in this sweep.
- first_err_data  out  DATA_W  doutb value at the first mismatch.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1: clear err_count, first_err_*, done and the compare pipeline; load addrb=0; go to READ.
- READ: addrb increments by 1 each cycle. When addrb = 2^ADDR_W−1, go to DRAIN on the next edge. addrb then holds at its last value; it does not wrap to 0.
- DRAIN: lasts exactly RD_LAT cycles, then go to DONE.
- DONE: done=1. Hold all results until start.
- Compare pipeline: a shift register RD_LAT deep carries {valid, addr}. Its valid input is 1 in READ, 0 otherwise. At the pipeline output, when valid=1:
  - expected = {~addr, addr};
  - if doutb != expected: pulse mismatch; increment err_count, saturating;
  - if this is the first error of the sweep: latch addr into first_err_addr and doutb into first_err_data.
- start during READ or DRAIN: ignored.
- Reset reached from any state: return to IDLE, clear the pipeline, and clear all outputs.
- Reset values:
  - addrb = 0, busy = 0, done = 0, pass = 0, mismatch = 0;
  - err_count = 0, first_err_addr = 0, first_err_data = 0.
- first_err_* are meaningful only when err_count != 0.

## Timing
- Edge E0 samples start. Address k is driven on addrb during the cycle after edge E(k), for k = 0..2^ADDR_W−1.
- doutb for address k is compared at edge E(k+RD_LAT+1). mismatch and err_count update at that same edge.
- busy rises after E0 and falls after edge E(2^ADDR_W+RD_LAT).
- done and pass are registered and rise after edge E(2^ADDR_W+RD_LAT). With default parameters this is edge 257.
- All outputs are registered; no combinational path from doutb to any output.
- Back-to-back sweeps: start held high in DONE restarts the sweep on the next edge, and done drops that edge.

## Test plan
- RAM pre-filled with {~a,a}; pulse start -> done at E257, pass=1, err_count=0, mismatch never asserted, busy high for exactly 257 cycles.
- RAM word 0x37 corrupted to 16'h0000 and word 0xA0 corrupted to 16'hFFFF -> err_count=2, first_err_addr=8'h37, first_err_data=16'h0000, pass=0, and exactly two one-cycle mismatch pulses.
- RAM model with RD_LAT=3, every word wrong -> err_count=256; addrb stops at 8'hFF; done rises at E259.
- start pulsed again at cycle 100 of a sweep -> ignored; sweep finishes at E257. A subsequent start in DONE clears err_count to 0 and re-sweeps.
- RSTN asserted mid-READ at addrb=8'h80 -> all outputs go to reset values at once. After release, start gives a clean full sweep.
- Saturation: ADDR_W=8, with err_count forced near the limit via a bench-driven long-run build (or a small-width variant of the counter) -> the counter holds at its maximum value and does not wrap to 0.
